rs_syndrome_calc: RTL
=====================

// Module: rs_syndrome_calc
// PURPOSE
//  RS decoder front end; sits directly upstream of the Berlekamp-Massey stage.
//  Takes received codeword bytes, highest-degree byte first, one byte per handshake.
//  Computes NSYM syndromes S_j = r(alpha^(j+FCR)) over GF(2^8), poly 0x11D, using per-syndrome Horner cells.
//  Presents them as one packed word with a valid/ready handshake to the BM data_in/valid_in.
// PARAMETERS
//  CW_LEN   255  codeword length in bytes; legal range NSYM+1..255
//  NSYM     16   number of syndromes; must be 16 to match BM data_in width
//  FCR      0    first consecutive root exponent; S_0 = r(alpha^FCR)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        synchronous active-low reset
//  in_data    in   8        received codeword byte
//  in_valid   in   1        in_data valid
//  in_ready   out  1        byte accepted when in_valid & in_ready
//  syn_out    out  NSYM*8   S_j at [j*8 +: 8]; feeds BM data_in
//  syn_valid  out  1        syn_out valid; feeds BM valid_in
//  syn_ready  in   1        top level ties to ~bm_busy & ~bm_valid_out
//  syn_zero   out  1        all syndromes zero; only with RS_SYN_ZERO_DET_EN
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=ACC, byte counter=0, all S_j=0, syn_valid=0, syn_zero=0; in_ready=1 after reset.
//  - FSM, 2 states:
//    ACC:  in_ready=1, syn_valid=0. On each accepted byte:
//          cnt==0: S_j <= in_data. Fresh start; no clear cycle.
//          else:   S_j <= (S_j * alpha^(j+FCR)) ^ in_data.
//          Accepted byte with cnt==CW_LEN-1 -> cnt<=0, go OUT.
//    OUT:  in_ready=0, syn_valid=1, syn_out held stable.
//          syn_valid & syn_ready -> go ACC next cycle.
//  - Latency: last byte accepted at cycle t -> syn_valid=1 from t+1.
//  - Turnaround: one bubble cycle. in_ready returns 1 the cycle after the output handshake.
//  - in_valid=0 gaps inside a codeword: counter and S_j hold; gaps of any length are legal.
//  - syn_ready low: syn_valid stays 1 and syn_out stays stable indefinitely; no bytes are taken.
//  - syn_out is registered and keeps its last value while in ACC. Consumers qualify it with syn_valid only.
//  - Counter: $clog2(CW_LEN) bits; no wrap, because it is cleared on the last byte.
//  - Reset mid-codeword: partial syndromes and count are discarded. The next byte after reset is treated as cnt==0.
//  - Reset in OUT: the pending result is dropped; syn_valid=0 on the next cycle.
// CONFIGURATION
//  RS_SYN_ZERO_DET_EN defined:
//   - syn_zero is registered and updated on the ACC->OUT transition: 1 iff every next-state S_j==0.
//   - It is valid while syn_valid=1 and is cleared on return to ACC.
//   - Top level may use it to bypass BM/Chien for error-free codewords.
//  RS_SYN_ZERO_DET_EN undefined:
//   - syn_zero is tied to 0 and the compare logic is absent.
//   - The port still exists, so the top level is identical in both builds.
// STRUCTURE
//  - Shared package rs_pkg:
//    GF_POLY=8'h1D, RS_NSYM=16, RS_CW_LEN=255;
//    function gf_alpha_pow(k) for elaboration-time constants;
//    localparams for the FSM state encoding (ACC, OUT).
//  - Sub-module rs_syn_cell: one Horner cell (S register, constant multiply by alpha^k via existing gf256_mul with constant b, XOR, load/first control).
//    Generated NSYM times with k=j+FCR.
//  - Top module holds the FSM, the counter, the handshake and the zero detect.
// TESTING  (CW_LEN=255, NSYM=16, FCR=0)
//  1. All-zero codeword, 255 bytes back-to-back -> syn_valid at t+1, syn_out=128'h0, syn_zero=1 (macro on).
//  2. Zeros except last byte=8'h01 -> every S_j=8'h01, syn_zero=0.
//  3. Zeros except byte 254 (degree 1)=8'h01 -> S_0..S_7=01,02,04,08,10,20,40,80; S_8=1D, S_9=3A.
//  4. Hold syn_ready=0 for 5 cycles after the case-3 result:
//     syn_valid=1, syn_out unchanged, in_ready=0 throughout; raise syn_ready -> in_ready=1 the next cycle.
//  5. Random in_valid gaps (~30% idle) in case 3 -> identical syn_out; syn_valid only after the 255th accepted byte.
//  6. rst_n=0 for 1 cycle after 100 bytes, then full case-2 codeword -> all S_j=8'h01. Same check with reset asserted in OUT.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: GF(2^8) field constants, code sizes,
// syndrome FSM encoding and elaboration-time power-of-alpha helper.
package rs_pkg;

  localparam int unsigned GF_W      = 8;
  localparam logic [7:0]  GF_POLY   = 8'h1D;
  localparam int unsigned RS_NSYM   = 16;
  localparam int unsigned RS_CW_LEN = 255;

  localparam logic ST_ACC_ENC = 1'b0;
  localparam logic ST_OUT_ENC = 1'b1;

  typedef enum logic {
    ST_ACC = ST_ACC_ENC,
    ST_OUT = ST_OUT_ENC
  } syn_state_t;

  // Multiply by alpha (x) modulo x^8 + x^4 + x^3 + x^2 + 1.
  function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
    return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? GF_POLY : 8'h00);
  endfunction

  // alpha^k, used only to build constant multiplier operands.
  function automatic logic [GF_W-1:0] gf_alpha_pow(input int unsigned k);
    logic [GF_W-1:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < (k % 255); i++) begin
      r = gf_xtime(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Byte-stream input and packed-syndrome output handshake of the syndrome stage.
interface rs_syndrome_calc_if #(
  parameter int unsigned NSYM = rs_pkg::RS_NSYM
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NSYM*8-1:0] syn_out;
  logic              syn_valid;
  logic              syn_ready;
  logic              syn_zero;

  modport master (
    output in_data, in_valid, syn_ready,
    input  in_ready, syn_out, syn_valid, syn_zero
  );

  modport slave (
    input  in_data, in_valid, syn_ready,
    output in_ready, syn_out, syn_valid, syn_zero
  );
endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, poly 0x11D; a constant b folds to XOR trees.
module gf256_mul
  import rs_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  output logic [GF_W-1:0] p_c
);

  logic [GF_W-1:0] acc;
  logic [GF_W-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    p_c = acc;
  end

endmodule

// File: rtl/rs_syn_cell.sv
// One Horner syndrome cell: S <= first ? d : S*alpha^K ^ d.
// With RS_SYN_ZERO_DET_EN the pre-register next value is exported for zero detect.
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int unsigned K = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            first,
  input  logic [GF_W-1:0] din,
  output logic [GF_W-1:0] s
`ifdef RS_SYN_ZERO_DET_EN
  ,
  output logic [GF_W-1:0] s_next_c
`endif
);

  localparam logic [GF_W-1:0] ALPHA_K = gf_alpha_pow(K);

  logic [GF_W-1:0] prod_c;
  logic [GF_W-1:0] nxt_c;

  gf256_mul u_mul (
    .a   (s),
    .b   (ALPHA_K),
    .p_c (prod_c)
  );

  // First byte of a codeword overwrites, so no clear cycle is needed between words.
  assign nxt_c = first ? din : (prod_c ^ din);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= '0;
    end else if (load) begin
      s <= nxt_c;
    end
  end

`ifdef RS_SYN_ZERO_DET_EN
  assign s_next_c = nxt_c;
`endif

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS syndrome front end: NSYM Horner cells, byte counter and ACC/OUT handshake FSM.
// Optional all-zero syndrome flag built when RS_SYN_ZERO_DET_EN is defined.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int unsigned CW_LEN = RS_CW_LEN,
  parameter int unsigned NSYM   = RS_NSYM,
  parameter int unsigned FCR    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rs_syndrome_calc_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CW_LEN);

  syn_state_t               state;
  syn_state_t               state_next;
  logic [CNT_W-1:0]         cnt;
  logic                     in_ready_q;
  logic                     syn_valid_q;
  logic                     accept_c;
  logic                     first_c;
  logic                     last_c;
  logic [NSYM-1:0][GF_W-1:0] syn;

  assign accept_c = bus.in_valid && in_ready_q;
  assign first_c  = (cnt == '0);
  assign last_c   = accept_c && (cnt == CNT_W'(CW_LEN - 1));

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (last_c) state_next = ST_OUT;
      ST_OUT:  if (syn_valid_q && bus.syn_ready) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // State, handshake flags and byte counter; flags track the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      syn_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == ST_ACC);
      syn_valid_q <= (state_next == ST_OUT);
      if (accept_c) begin
        cnt <= last_c ? '0 : cnt + CNT_W'(1);
      end
    end
  end

`ifdef RS_SYN_ZERO_DET_EN
  logic [NSYM-1:0][GF_W-1:0] s_next;
  logic                      all_zero_c;
  logic                      syn_zero_q;
`endif

  for (genvar j = 0; j < NSYM; j++) begin : g_cell
    rs_syn_cell #(
      .K (j + FCR)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept_c),
      .first    (first_c),
      .din      (bus.in_data),
      .s        (syn[j])
`ifdef RS_SYN_ZERO_DET_EN
      ,
      .s_next_c (s_next[j])
`endif
    );
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.syn_valid = syn_valid_q;
  assign bus.syn_out   = syn;

`ifdef RS_SYN_ZERO_DET_EN
  assign all_zero_c = (s_next == '0);

  // Captured on entry to OUT from the values being loaded, cleared on return to ACC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syn_zero_q <= 1'b0;
    end else if (state == ST_ACC && state_next == ST_OUT) begin
      syn_zero_q <= all_zero_c;
    end else if (state_next == ST_ACC) begin
      syn_zero_q <= 1'b0;
    end
  end

  assign bus.syn_zero = syn_zero_q;
`else
  assign bus.syn_zero = 1'b0;
`endif

endmodule
